lfsr_param: RTL
===============

LFSR_PARAM -- requirements
Module: lfsr_param

Interface
REQ-001 Parameter WIDTH, default 4: register width in bits, legal range 3..32.
REQ-002 Parameter TAPS, default 4'b1100 (WIDTH bits): feedback tap mask; bit i set means state bit i is a tap.
REQ-003 Parameter SEED, default all-ones (WIDTH bits): reset value and lock-up recovery value; must be non-zero.
REQ-004 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  advances the register one step in the cycle it is sampled high.
REQ-007 mode  in  1  0 = Fibonacci, 1 = Galois; sampled on every step.
REQ-008 load  in  1  loads load_data in place of a step.
REQ-009 load_data  in  WIDTH  value written when load=1.
REQ-010 q  out  WIDTH  current register state.
REQ-011 serial_out  out  1  equals q[WIDTH-1].
REQ-012 step_cnt  out  WIDTH  number of steps since the last reset or load, modulo 2^WIDTH.
REQ-013 period_done  out  1  one-cycle pulse when the state returns to its start value.
REQ-014 period_len  out  WIDTH  step_cnt value captured at the last period_done; 0 until the first period completes.
REQ-015 lockup  out  1  one-cycle pulse when an all-zero state is replaced by SEED.

Function
REQ-016 Priority per cycle SHALL be: rst, then load, then en, then hold.
REQ-017 Fibonacci step SHALL set next = {q[WIDTH-2:0], fb}, where fb = XOR of q[i] over all i with TAPS[i]=1.
REQ-018 Galois step SHALL set next[0] = q[WIDTH-1] and next[i] = q[i-1] ^ (q[WIDTH-1] & TAPS[i-1]) for i = 1..WIDTH-1.
REQ-019 Any step taken from q == 0 SHALL set q = SEED instead of the mode result, pulse lockup, and clear step_cnt to 0.
REQ-020 load SHALL set q = load_data, set the start register to load_data, and clear step_cnt to 0; it SHALL NOT pulse period_done or lockup.
REQ-021 Loading 0 SHALL be accepted; the next enabled step then applies REQ-019.
REQ-022 A normal step SHALL increment step_cnt, wrapping from 2^WIDTH-1 to 0.
REQ-023 When a normal step produces next == start register, period_done SHALL pulse in the following cycle, period_len SHALL capture step_cnt+1 (truncated to WIDTH bits), and step_cnt SHALL restart at 0.
REQ-024 A change of mode between steps SHALL NOT reset step_cnt or the start register.
REQ-025 With en=0 and load=0, q, step_cnt and period_len SHALL hold, and the pulse outputs SHALL be 0.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 On rst: q = SEED, start register = SEED, step_cnt = 0, period_len = 0, period_done = 0, lockup = 0.
REQ-028 rst asserted during any operation, including in the same cycle as load or en, SHALL take effect on that edge and discard the other inputs.

Structure
REQ-029 The mode encodings (MODE_FIB = 0, MODE_GAL = 1) SHALL reside in the shared package lfsr_pkg.
REQ-030 The next-state computation SHALL be a combinational sub-module lfsr_next (inputs q, mode; output next), reused by later LFSR blocks.
REQ-031 The design SHALL contain no per-bit flip-flop instances; state SHALL be one WIDTH-bit register.

Verification
REQ-032 Defaults, rst, then 4 en cycles in mode=0 -> q = F, E, C, 8, 1.
REQ-033 Defaults, mode=0, 15 consecutive en cycles -> q returns to F, period_done pulses exactly once, period_len = 15.
REQ-034 Defaults, mode=1, one en cycle from F -> q = 7.
REQ-035 load with load_data=0, then en -> q = F, lockup pulses once, step_cnt = 0.
REQ-036 load=1 and en=1 together with load_data=5 -> q = 5 and step_cnt = 0; rst during a run -> q = F on that edge.
REQ-037 WIDTH=16, TAPS=16'hB400, mode=0, 65535 steps -> period_done pulses, period_len = 65535, and lockup never pulses.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR family: mode encodings used by every LFSR block.
package lfsr_pkg;

    typedef enum logic {
        MODE_FIB = 1'b0,
        MODE_GAL = 1'b1
    } lfsr_mode_e;

endpackage

// File: rtl/lfsr_next.sv
// Combinational one-step LFSR next-state function, Fibonacci or Galois form.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH = 4,
    parameter logic [WIDTH-1:0]  TAPS  = 4'b1100
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic [WIDTH-1:0] next
);

    logic fb;

    always_comb begin
        fb   = ^(q & TAPS);
        next = {q[WIDTH-2:0], fb};
        if (lfsr_mode_e'(mode) == MODE_GAL) begin
            // Rotate left, then fold the outgoing MSB into every tapped position.
            next = {q[WIDTH-2:0], q[WIDTH-1]}
                 ^ ({WIDTH{q[WIDTH-1]}} & {TAPS[WIDTH-2:0], 1'b0});
        end
    end

endmodule

// File: rtl/lfsr_param.sv
// Parameterised LFSR with load, lock-up recovery, step counting and period detection.
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH = 4,
    parameter logic [WIDTH-1:0]  TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0]  SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic [WIDTH-1:0] step_cnt,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len,
    output logic             lockup
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] period_len_q, period_len_d;
    logic             period_done_q, period_done_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .q    (q_q),
        .mode (mode),
        .next (next)
    );

    always_comb begin
        q_d           = q_q;
        start_d       = start_q;
        step_cnt_d    = step_cnt_q;
        period_len_d  = period_len_q;
        period_done_d = 1'b0;
        lockup_d      = 1'b0;
        if (load) begin
            q_d        = load_data;
            start_d    = load_data;
            step_cnt_d = '0;
        end else if (en) begin
            if (q_q == '0) begin
                // All-zero is a fixed point of both forms; recover from SEED.
                q_d        = SEED;
                step_cnt_d = '0;
                lockup_d   = 1'b1;
            end else begin
                q_d = next;
                if (next == start_q) begin
                    period_done_d = 1'b1;
                    period_len_d  = step_cnt_q + WIDTH'(1);
                    step_cnt_d    = '0;
                end else begin
                    step_cnt_d = step_cnt_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q           <= SEED;
            start_q       <= SEED;
            step_cnt_q    <= '0;
            period_len_q  <= '0;
            period_done_q <= 1'b0;
            lockup_q      <= 1'b0;
        end else begin
            q_q           <= q_d;
            start_q       <= start_d;
            step_cnt_q    <= step_cnt_d;
            period_len_q  <= period_len_d;
            period_done_q <= period_done_d;
            lockup_q      <= lockup_d;
        end
    end

    assign q           = q_q;
    assign serial_out  = q_q[WIDTH-1];
    assign step_cnt    = step_cnt_q;
    assign period_done = period_done_q;
    assign period_len  = period_len_q;
    assign lockup      = lockup_q;

endmodule
